// File: rtl/xt_hb_master_arbiter_pkg.sv
// Shared types for the XT_HB master arbiter: FSM state and the per-master
// request bundle.
package xt_hb_master_arbiter_pkg;

  localparam int HB_ADDR_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } hb_arb_state_e;

  // One master's view of the bus, as a bundle.
  typedef struct packed {
    logic                     read;
    logic                     write;
    logic [HB_ADDR_WIDTH-1:0] raddr;
    logic [HB_ADDR_WIDTH-1:0] waddr;
    logic [31:0]              wdata;
    logic [1:0]               write_width;
  } hb_master_in_t;

endpackage

// File: rtl/xt_hb_master_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester after 'last'
// (wrapping) wins; returns one-hot and index.
module xt_hb_master_arbiter_rr_picker #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  gnt
);

  int c;

  // Scan from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    c   = 0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(last) + k) % N;
      if (req[c]) begin
        any = 1'b1;
        idx = IW'(c);
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/xt_hb_master_arbiter.sv
// Round-robin arbiter sharing the single XT_HB master slot between several
// masters. One ownership per transaction; released on finish, abort or
// watchdog expiry. Owner inputs pass through to the bus combinationally.
module xt_hb_master_arbiter
  import xt_hb_master_arbiter_pkg::*;
#(
  parameter  int MASTER_NUM = 2,
  parameter  int ADDR_WIDTH = HB_ADDR_WIDTH,
  parameter  int TIMEOUT    = 1024,
  localparam int MW         = $clog2(MASTER_NUM),
  localparam int CW         = $clog2(TIMEOUT)
) (
  input  logic                                 hb_clk,
  input  logic                                 rst_sync_n,
  input  logic [MASTER_NUM-1:0]                m_read,
  input  logic [MASTER_NUM-1:0]                m_write,
  input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_raddr,
  input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_waddr,
  input  logic [MASTER_NUM-1:0][31:0]          m_wdata,
  input  logic [MASTER_NUM-1:0][1:0]           m_write_width,
  output logic [MASTER_NUM-1:0]                m_grant,
  output logic [MASTER_NUM-1:0]                m_stall,
  output logic                                 bus_read,
  output logic                                 bus_write,
  output logic [ADDR_WIDTH-1:0]                bus_raddr,
  output logic [ADDR_WIDTH-1:0]                bus_waddr,
  output logic [31:0]                          bus_wdata,
  output logic [1:0]                           bus_write_width,
  input  logic                                 bus_read_finish,
  input  logic                                 bus_write_finish,
  output logic                                 timeout_irq,
  output logic [MW-1:0]                        err_master
);

  hb_arb_state_e         state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [MW-1:0]         owner_q, owner_d;
  logic [MW-1:0]         last_q, last_d;
  logic [MW-1:0]         err_q, err_d;
  logic                  pend_r_q, pend_r_d;
  logic                  pend_w_q, pend_w_d;
  logic [CW-1:0]         wd_q, wd_d;
  logic                  irq_q, irq_d;

  logic [MASTER_NUM-1:0] req;
  logic                  pick_any;
  logic [MW-1:0]         pick_idx;
  logic [MASTER_NUM-1:0] pick_gnt;
  logic                  owned, nxt_pr, nxt_pw, finishing;

  assign req = m_read | m_write;

  xt_hb_master_arbiter_rr_picker #(.N(MASTER_NUM)) u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx),
    .gnt  (pick_gnt)
  );

  // Finishes only count against a pend that is still outstanding.
  assign owned     = (state_q == OWNED);
  assign nxt_pr    = pend_r_q & ~bus_read_finish;
  assign nxt_pw    = pend_w_q & ~bus_write_finish;
  assign finishing = owned & ~nxt_pr & ~nxt_pw;

  // Bus forwarding from the owner, stall back to everyone else.
  always_comb begin
    m_grant         = grant_q;
    m_stall         = req & ~(grant_q & {MASTER_NUM{finishing}});
    bus_read        = owned & m_read[owner_q] & pend_r_q;
    bus_write       = owned & m_write[owner_q] & pend_w_q;
    bus_raddr       = owned ? m_raddr[owner_q] : '0;
    bus_waddr       = owned ? m_waddr[owner_q] : '0;
    bus_wdata       = owned ? m_wdata[owner_q] : '0;
    bus_write_width = owned ? m_write_width[owner_q] : '0;
    timeout_irq     = irq_q;
    err_master      = err_q;
  end

  // Next-state: arbitrate in IDLE; in OWNED release on finish > abort > watchdog.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    last_d   = last_q;
    err_d    = err_q;
    pend_r_d = pend_r_q;
    pend_w_d = pend_w_q;
    wd_d     = wd_q;
    irq_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = OWNED;
          grant_d  = pick_gnt;
          owner_d  = pick_idx;
          pend_r_d = m_read[pick_idx];
          pend_w_d = m_write[pick_idx];
          wd_d     = '0;
        end
      end
      OWNED: begin
        pend_r_d = nxt_pr;
        pend_w_d = nxt_pw;
        if (finishing || !req[owner_q] || wd_q == CW'(TIMEOUT - 1)) begin
          state_d  = IDLE;
          grant_d  = '0;
          pend_r_d = 1'b0;
          pend_w_d = 1'b0;
          if (finishing) begin
            last_d = owner_q;
          end else if (req[owner_q]) begin
            // Watchdog expiry: owner still requesting, nothing finished.
            irq_d  = 1'b1;
            err_d  = owner_q;
            last_d = owner_q;
          end
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge hb_clk) begin
    if (!rst_sync_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      last_q   <= MW'(MASTER_NUM - 1);
      err_q    <= '0;
      pend_r_q <= 1'b0;
      pend_w_q <= 1'b0;
      wd_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      err_q    <= err_d;
      pend_r_q <= pend_r_d;
      pend_w_q <= pend_w_d;
      wd_q     <= wd_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_xt_hb_master_arbiter.sv
// Randomized bench for xt_hb_master_arbiter against a transaction-level model.
module tb_xt_hb_master_arbiter;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int TO = 8;
  localparam int MW = $clog2(N);

  logic                 hb_clk = 1'b0;
  logic                 rst_sync_n = 1'b0;
  logic [N-1:0]         m_read, m_write;
  logic [N-1:0][AW-1:0] m_raddr, m_waddr;
  logic [N-1:0][31:0]   m_wdata;
  logic [N-1:0][1:0]    m_write_width;
  logic [N-1:0]         m_grant, m_stall;
  logic                 bus_read, bus_write;
  logic [AW-1:0]        bus_raddr, bus_waddr;
  logic [31:0]          bus_wdata;
  logic [1:0]           bus_write_width;
  logic                 bus_read_finish, bus_write_finish;
  logic                 timeout_irq;
  logic [MW-1:0]        err_master;

  xt_hb_master_arbiter #(.MASTER_NUM(N), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .hb_clk(hb_clk), .rst_sync_n(rst_sync_n),
    .m_read(m_read), .m_write(m_write), .m_raddr(m_raddr), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_write_width(m_write_width),
    .m_grant(m_grant), .m_stall(m_stall),
    .bus_read(bus_read), .bus_write(bus_write), .bus_raddr(bus_raddr), .bus_waddr(bus_waddr),
    .bus_wdata(bus_wdata), .bus_write_width(bus_write_width),
    .bus_read_finish(bus_read_finish), .bus_write_finish(bus_write_finish),
    .timeout_irq(timeout_irq), .err_master(err_master)
  );

  always #5 hb_clk = ~hb_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: owner index (-1 = nobody), outstanding read/write, cycles owned.
  int own = -1, cnt = 0, lastm = N - 1, errm = 0, rel = -1;
  bit pr = 0, pw = 0, mirq = 0;
  int irq_model = 0, irq_dut = 0;

  initial begin
    logic [N-1:0]         req, es, eg;
    logic [AW-1:0]        ea_r, ea_w;
    logic [31:0]          ed;
    logic [1:0]           ew;
    bit                   nr, nw, fin, ebr, ebw, aborted;
    int                   pf, w;

    m_read = '0; m_write = '0; m_raddr = '0; m_waddr = '0;
    m_wdata = '0; m_write_width = '0;
    bus_read_finish = 1'b0; bus_write_finish = 1'b0;
    @(posedge hb_clk); #1;

    for (int cyc = 0; cyc < 2400; cyc++) begin
      // ---- drive: master behaviour and device finishes ----
      rst_sync_n = !(cyc < 3 || (cyc % 400) == 250);
      pf = (cyc < 800) ? 35 : (cyc < 1600) ? 5 : 30;
      if (rel >= 0) begin
        m_read[rel] = 1'b0;
        m_write[rel] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        aborted = 0;
        if (own == i && (m_read[i] | m_write[i]) && $urandom_range(99) < 2) begin
          m_read[i] = 1'b0;
          m_write[i] = 1'b0;
          aborted = 1;
        end
        if (!aborted && !(m_read[i] | m_write[i]) && $urandom_range(99) < 25) begin
          m_read[i]  = 1'($urandom_range(1));
          m_write[i] = 1'($urandom_range(1));
          if (!m_read[i] && !m_write[i]) m_read[i] = 1'b1;
          m_raddr[i] = AW'($urandom);
          m_waddr[i] = AW'($urandom);
          m_wdata[i] = $urandom;
          m_write_width[i] = 2'($urandom_range(2));
        end
      end
      bus_read_finish  = ($urandom_range(99) < pf);
      bus_write_finish = ($urandom_range(99) < pf);

      // ---- check expected outputs away from the clock edge ----
      @(negedge hb_clk);
      req  = m_read | m_write;
      nr   = pr && !bus_read_finish;
      nw   = pw && !bus_write_finish;
      fin  = (own >= 0) && !nr && !nw;
      eg   = '0; es = '0;
      ebr  = 0; ebw = 0; ea_r = '0; ea_w = '0; ed = '0; ew = '0;
      if (own >= 0) begin
        eg[own] = 1'b1;
        ebr  = m_read[own] && pr;
        ebw  = m_write[own] && pw;
        ea_r = m_raddr[own];
        ea_w = m_waddr[own];
        ed   = m_wdata[own];
        ew   = m_write_width[own];
      end
      for (int i = 0; i < N; i++) es[i] = req[i] && !(i == own && fin);
      chk("grant", 64'(m_grant), 64'(eg));
      chk("stall", 64'(m_stall), 64'(es));
      chk("bus_read", 64'(bus_read), 64'(ebr));
      chk("bus_write", 64'(bus_write), 64'(ebw));
      chk("bus_raddr", 64'(bus_raddr), 64'(ea_r));
      chk("bus_waddr", 64'(bus_waddr), 64'(ea_w));
      chk("bus_wdata", 64'(bus_wdata), 64'(ed));
      chk("bus_wwidth", 64'(bus_write_width), 64'(ew));
      chk("timeout_irq", 64'(timeout_irq), 64'(mirq));
      chk("err_master", 64'(err_master), 64'(errm));
      if (timeout_irq === 1'b1) irq_dut++;

      // ---- advance the model to the next cycle ----
      rel = -1;
      if (!rst_sync_n) begin
        own = -1; pr = 0; pw = 0; cnt = 0; lastm = N - 1; errm = 0; mirq = 0;
      end else begin
        mirq = 0;
        if (own < 0) begin
          w = -1;
          for (int k = 1; k <= N && w < 0; k++)
            if (req[(lastm + k) % N]) w = (lastm + k) % N;
          if (w >= 0) begin
            own = w; pr = m_read[w]; pw = m_write[w]; cnt = 0;
          end
        end else if (fin) begin
          lastm = own; rel = own; own = -1;
        end else if (!req[own]) begin
          rel = own; own = -1;
        end else if (cnt == TO - 1) begin
          mirq = 1; irq_model++; errm = own; lastm = own; rel = own; own = -1;
        end else begin
          cnt++; pr = nr; pw = nw;
        end
      end

      @(posedge hb_clk); #1;
    end

    chk("irq_count", 64'(irq_dut), 64'(irq_model));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
